// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin owner of the shared tri-state sysbus and RAM
// chip select for up to four masters. The grant is registered and one-hot.
// Every tenure is followed by one dead TURN cycle, so two drivers can never
// overlap on the bus.
// Optional hold timeout: define SYSBUS_ARB_TIMEOUT_EN to add the hold counter,
// forced release and timeout_err. Without it, a tenure ends only when the owner
// drops req, lock is ignored and timeout_err stays 0.
module sysbus_arbiter #(
    parameter int WORD_W   = 8,
    parameter int N_REQ    = 2,
    parameter int MAX_HOLD = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    input  logic [N_REQ-1:0] rnw_in,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       owner,
    output logic             bus_busy,
    output logic             CS,
    output logic             R_NW,
    output logic             timeout_err
);

    // WORD_W carries no datapath here; it is only range-checked with the rest.
    if (N_REQ < 2 || N_REQ > 4 || MAX_HOLD < 1 || MAX_HOLD > 255 || WORD_W < 1) begin : g_param_check
        $error("sysbus_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] req_x;
    logic [3:0] rnw_x;
    logic [1:0] winner;
    logic [1:0] ptr_next;
    logic       owner_req;
    logic       hold_expired;

    // Widen the request vectors to four bits so a 2-bit owner index is always in range.
    assign req_x     = 4'(req);
    assign rnw_x     = 4'(rnw_in);
    assign owner_req = req_x[owner];

    // First requester at or after p, scanning upward modulo N_REQ. The scan
    // runs from the farthest offset to the nearest so the nearest wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [2:0] s;
        w = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            s = {1'b0, p} + 3'(i);
            if (s >= 3'(N_REQ)) s = s - 3'(N_REQ);
            if (r[s[1:0]]) w = s[1:0];
        end
        return w;
    endfunction

    assign winner   = rr_pick(req_x, ptr);
    assign ptr_next = (winner == 2'(N_REQ - 1)) ? 2'd0 : winner + 2'd1;

`ifdef SYSBUS_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [3:0]        lock_x;
    logic [HOLD_W-1:0] hold_cnt;
    logic              owner_lock;

    assign lock_x       = 4'(lock);
    assign owner_lock   = lock_x[owner];
    assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && !owner_lock;

    // Count unlocked cycles of the current tenure; zero outside GNT or while locked, saturating.
    always_ff @(posedge clock) begin
        if (reset || state != GNT || owner_lock) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`else
    logic lock_unused;

    assign lock_unused  = ^lock;
    assign hold_expired = 1'b0;
`endif

    // Arbitration FSM: IDLE picks a winner, GNT holds it, TURN leaves the bus undriven for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            grant       <= '0;
            owner       <= 2'd0;
            bus_busy    <= 1'b0;
            CS          <= 1'b0;
            R_NW        <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GNT;
                        grant    <= N_REQ'(4'b0001 << winner);
                        owner    <= winner;
                        ptr      <= ptr_next;
                        bus_busy <= 1'b1;
                        CS       <= 1'b1;
                        R_NW     <= 1'b1;
                    end
                end
                GNT: begin
                    // A release on the same edge as an expiry wins: no error pulse.
                    if (!owner_req || hold_expired) begin
                        state       <= TURN;
                        grant       <= '0;
                        bus_busy    <= 1'b0;
                        CS          <= 1'b0;
                        R_NW        <= 1'b1;
                        timeout_err <= owner_req;
                    end else begin
                        R_NW <= rnw_x[owner];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter with three requesters and MAX_HOLD=4.
// The reference model tracks the bus as idle / owned / turnaround and the
// number of unlocked cycles held by the owner. Directed sequences pin the
// model with literal expectations. Timeout sequences apply when
// SYSBUS_ARB_TIMEOUT_EN is defined.
module tb_sysbus_arbiter;

    localparam int N  = 3;
    localparam int MH = 4;
`ifdef SYSBUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clock  = 1'b0;
    logic         reset  = 1'b1;
    logic [N-1:0] req    = '0;
    logic [N-1:0] lock   = '0;
    logic [N-1:0] rnw_in = '1;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic         bus_busy;
    logic         CS;
    logic         R_NW;
    logic         timeout_err;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    sysbus_arbiter #(.WORD_W(8), .N_REQ(N), .MAX_HOLD(MH)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .lock       (lock),
        .rnw_in     (rnw_in),
        .grant      (grant),
        .owner      (owner),
        .bus_busy   (bus_busy),
        .CS         (CS),
        .R_NW       (R_NW),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = nobody on the bus, 1 = owned, 2 = dead cycle.
    int         m_phase = 0;
    logic [1:0] m_own   = 2'd0;
    int         m_ptr   = 0;
    int         m_run   = 0;
    bit         m_rnw   = 1'b1;
    bit         m_terr  = 1'b0;
    int         m_c;
    bit         m_found;

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_own = 2'd0; m_ptr = 0; m_run = 0; m_rnw = 1'b1; m_terr = 1'b0;
        end else begin
            m_terr = 1'b0;
            if (m_phase == 0) begin
                m_found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (!m_found && req[m_c[1:0]]) begin
                        m_found = 1'b1;
                        m_own   = m_c[1:0];
                    end
                end
                if (m_found) begin
                    m_phase = 1;
                    m_ptr   = (int'(m_own) + 1) % N;
                    m_run   = 0;
                    m_rnw   = 1'b1;
                end
            end else if (m_phase == 1) begin
                if (!req[m_own]) begin
                    m_phase = 2; m_rnw = 1'b1;
                end else if (TO_EN && !lock[m_own] && m_run == MH - 1) begin
                    m_phase = 2; m_rnw = 1'b1; m_terr = 1'b1;
                end else begin
                    m_rnw = rnw_in[m_own];
                    if (TO_EN && lock[m_own]) m_run = 0;
                    else if (m_run < MH) m_run++;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("grant", 32'(grant), (m_phase == 1) ? (32'd1 << m_own) : 32'd0);
            chk("bus_busy", 32'(bus_busy), 32'(m_phase == 1));
            chk("CS", 32'(CS), 32'(m_phase == 1));
            chk("R_NW", 32'(R_NW), 32'(m_rnw));
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
            if (m_phase == 1) chk("owner", 32'(owner), 32'(m_own));
        end
    end

    task automatic do_reset();
        reset = 1'b1; req = '0; lock = '0; rnw_in = '1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [N-1:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int zeros;

    initial begin
        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(bus_busy), 32'd0);
        chk("rst_CS", 32'(CS), 32'd0);
        chk("rst_R_NW", 32'(R_NW), 32'd1);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk_en = 1'b1;

        // Reset in the middle of master 1's tenure.
        req = 3'b010;
        @(negedge clock);
        chk("a_grant_m1", 32'(grant), 32'b010);
        chk("a_owner_m1", 32'(owner), 32'd1);
        reset = 1'b1; req = 3'b011;
        @(negedge clock);
        chk("a_rst_grant", 32'(grant), 32'd0);
        chk("a_rst_CS", 32'(CS), 32'd0);
        chk("a_rst_R_NW", 32'(R_NW), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("a_first_m0", 32'(grant), 32'b001);
        req = '0;
        repeat (3) @(negedge clock);

        // Round robin: all request, each owner keeps the bus 2 cycles.
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            zeros = 0;
            while (grant == '0 && zeros < 10) begin
                zeros++;
                @(negedge clock);
            end
            chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
            if (i > 0) chk("rr_gap", 32'(zeros), 32'd2);
            @(negedge clock);
            chk("rr_hold2", 32'(grant), 32'(rr_exp[i]));
            req = 3'b111 & ~rr_exp[i];
            @(negedge clock);
            chk("rr_release", 32'(grant), 32'd0);
            req = 3'b111;
        end
        req = '0;
        repeat (3) @(negedge clock);

        // R_NW pass-through for owner 1 writing; non-owner activity ignored.
        do_reset();
        rnw_in = 3'b101; req = 3'b010;
        @(negedge clock);
        chk("c_grant", 32'(grant), 32'b010);
        req = 3'b011; lock = 3'b001;
        @(negedge clock);
        chk("c_rnw_low", 32'(R_NW), 32'd0);
        chk("c_still_m1", 32'(grant), 32'b010);
        req = 3'b001;
        @(negedge clock);
        chk("c_grant_off", 32'(grant), 32'd0);
        chk("c_rnw_turn", 32'(R_NW), 32'd1);
        @(negedge clock);
        chk("c_idle", 32'(grant), 32'd0);
        @(negedge clock);
        chk("c_next_m0", 32'(grant), 32'b001);
        req = '0; lock = '0; rnw_in = '1;
        repeat (3) @(negedge clock);

`ifdef SYSBUS_ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD cycles, then master 1 takes over.
        do_reset();
        req = 3'b011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("d_hold", 32'(grant), 32'b001);
            chk("d_no_err", 32'(timeout_err), 32'd0);
        end
        @(negedge clock);
        chk("d_forced", 32'(grant), 32'd0);
        chk("d_err", 32'(timeout_err), 32'd1);
        @(negedge clock);
        chk("d_turn", 32'(grant), 32'd0);
        chk("d_err_pulse", 32'(timeout_err), 32'd0);
        @(negedge clock);
        chk("d_next_m1", 32'(grant), 32'b010);
        req = '0;
        repeat (3) @(negedge clock);

        // Lock holds the bus; release comes 4 cycles after lock drops.
        do_reset();
        req = 3'b001; lock = 3'b001;
        repeat (20) @(negedge clock);
        chk("e_locked", 32'(grant), 32'b001);
        lock = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("e_after_unlock", 32'(grant), 32'b001);
        end
        @(negedge clock);
        chk("e_release", 32'(grant), 32'd0);
        chk("e_err", 32'(timeout_err), 32'd1);
        req = '0;
        repeat (3) @(negedge clock);

        // Release on the same edge as expiry is a normal release.
        do_reset();
        req = 3'b001;
        repeat (4) @(negedge clock);
        chk("f_hold", 32'(grant), 32'b001);
        req = '0;
        @(negedge clock);
        chk("f_release", 32'(grant), 32'd0);
        chk("f_no_err", 32'(timeout_err), 32'd0);
        @(negedge clock);
        chk("f_idle_no_err", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clock);
`else
        // Without the timeout a tenure lasts as long as req, whatever lock does.
        do_reset();
        req = 3'b011;
        repeat (12) @(negedge clock);
        chk("g_no_timeout", 32'(grant), 32'b001);
        chk("g_no_err", 32'(timeout_err), 32'd0);
        req = 3'b010;
        @(negedge clock);
        chk("g_release", 32'(grant), 32'd0);
        repeat (2) @(negedge clock);
        chk("g_next_m1", 32'(grant), 32'b010);
        req = '0;
        repeat (3) @(negedge clock);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

Round-robin arbiter that shares the CPU's single tri-state `sysbus` and RAM chip-select between up to four bus masters. Typical masters are the sequencer, the input module and a display/DMA engine. It issues a registered one-hot grant and drives `CS`/`R_NW` on behalf of the current owner. A one-cycle turnaround with no owner between tenures guarantees that two drivers never overlap on `sysbus`. An optional hold timeout recovers the bus from a master that never releases it.

## Interface
- `WORD_W`, 8, system word width; carried for consistency with the other CPU blocks, no datapath here
- `N_REQ`, 2, number of requesters, legal range 2..4
- `MAX_HOLD`, 15, maximum unlocked tenure in cycles, legal range 1..255
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  N_REQ  per-master bus request, level, held for the whole tenure
- `lock`  in  N_REQ  per-master lock, meaningful only for the current owner, suppresses timeout
- `rnw_in`  in  N_REQ  per-master read(1)/write(0) intent
- `grant`  out  N_REQ  registered one-hot grant, all-zero when no owner
- `owner`  out  2  index of the current owner, valid only while `bus_busy`=1
- `bus_busy`  out  1  high exactly while a grant is active
- `CS`  out  1  RAM chip select, equals `bus_busy`
- `R_NW`  out  1  `rnw_in[owner]` registered while busy, 1 otherwise
- `timeout_err`  out  1  one-cycle pulse on a forced release

## Operation
- States:
  - IDLE: no owner.
  - GNT: a master owns the bus.
  - TURN: one dead cycle after every tenure.
- IDLE → GNT:
  - Condition: any `req` bit high at the edge.
  - Winner: the first requester at or after `ptr`, scanning upward modulo `N_REQ`.
  - Registered updates: `grant` is set to the one-hot of the winner, `owner` to the winner, and `ptr` to winner+1 mod `N_REQ`.
- GNT → TURN, normal release:
  - Condition: `req[owner]`=0 at the edge.
  - Registered updates: `grant` is cleared to 0; `CS` and `bus_busy` go to 0.
- GNT → TURN, forced release:
  - Condition: `hold_cnt`==`MAX_HOLD`-1, `lock[owner]`=0 and `req[owner]`=1.
  - Registered updates: `grant` is cleared to 0 and `timeout_err` is set to 1 for one cycle.
- TURN → IDLE: unconditional.
  - A requester that was waiting is granted on the following edge.
  - TURN therefore always lasts exactly one cycle with the bus undriven.
- Hold counter:
  - Width is $clog2(`MAX_HOLD`+1).
  - Cleared on entry to GNT.
  - Incremented each cycle in GNT while `lock[owner]`=0; saturates, no wrap.
  - Held at 0 while `lock[owner]`=1.
- Changes to `req`, `lock` and `rnw_in` of non-owners have no effect during GNT or TURN.
- Simultaneous release and timeout on the same edge: treated as a normal release, no `timeout_err`.
- A master whose `req` stays high after a forced release rejoins arbitration normally. Because `ptr` has already advanced past it, it has lowest priority in the next round.
- Reset values, applied on the first edge with `reset`=1 and valid mid-tenure:
  - `grant`=0, `owner`=0, `bus_busy`=0, `CS`=0, `R_NW`=1, `timeout_err`=0.
  - State = IDLE, `ptr`=0, `hold_cnt`=0.

## Timing
- Request to grant latency: `req` first high before edge k, with the arbiter in IDLE, gives `grant` high after edge k.
- Back-to-back tenures:
  - Owner drops `req` before edge k.
  - `grant` is 0 after edge k (TURN) and after k+1 (IDLE).
  - The next owner is granted after edge k+2.
- Minimum gap between grants is 2 cycles with the bus undriven.
- `R_NW` follows `rnw_in[owner]` with one cycle of latency while busy. A master must hold its intent stable for one cycle after grant before driving the bus.
- Unlocked maximum tenure is exactly `MAX_HOLD` cycles of `grant` high.

## Configuration
- `SYSBUS_ARB_TIMEOUT_EN` defined:
  - Hold counter, forced release and `timeout_err` are present, as described above.
- `SYSBUS_ARB_TIMEOUT_EN` undefined:
  - No hold counter.
  - A tenure ends only when `req[owner]` drops.
  - `lock` is ignored.
  - `timeout_err` is tied to 0.
  - `MAX_HOLD` has no effect.

## Test plan
- Reset mid-tenure:
  - Stimulus: assert `reset` while master 1 holds the bus.
  - Required: `grant`=00, `CS`=0, `R_NW`=1 after the edge. `req`=11 after reset grants master 0 first.
- Round-robin:
  - Stimulus: `N_REQ`=3, `req`=111 held, each master releasing after 2 cycles.
  - Required: grant order 001→010→100→001, with exactly 2 zero-grant cycles between tenures.
- Timeout, macro on, `MAX_HOLD`=4:
  - Stimulus: master 0 holds `req`=1, `lock`=0.
  - Required: `grant` high for exactly 4 cycles, then `timeout_err` pulses 1 cycle. With `req`=11, master 1 is granted 2 cycles later.
- Lock:
  - Stimulus: same as the timeout test with `lock[0]`=1 for 20 cycles.
  - Required: no forced release. Release happens 4 cycles after `lock` drops if `req` is still high.
- Simultaneous release and timeout:
  - Stimulus: drop `req[0]` at the edge where `hold_cnt`=`MAX_HOLD`-1.
  - Required: `timeout_err` stays 0 and the state enters TURN.
- `R_NW` pass-through:
  - Stimulus: owner 1 with `rnw_in[1]`=0.
  - Required: `R_NW`=0 one cycle after grant. `R_NW` returns to 1 in TURN.
